// File: rtl/keypad_pkg.sv
// keypad_pkg
// Definitions shared by the keypad blocks.
//   KEY_W          - width of a key code coming out of the interpreter
//   reader_state_t - handshake states of the key-entry reader
package keypad_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // waiting for a pending key
    ACK     = 2'd1,  // KeyRead asserted, waiting for KeyReady to fall
    RECOVER = 2'd2   // ack timed out, waiting for KeyReady to fall with no capture
  } reader_state_t;

endpackage

// File: rtl/key_fifo.sv
// key_fifo
// Synchronous FIFO holding captured key codes. There is no fall-through:
// a write into an empty FIFO becomes visible on the cycle after the write edge.
// Ports:
//   clk       in   clock, rising edge
//   rstN      in   asynchronous active-low reset
//   clear     in   synchronous flush, overrides push and pop
//   push      in   write pushData (caller guarantees the FIFO is not full)
//   pushData  in   KEY_W-bit value to write
//   popReady  in   consumer ready; a pop happens when headValid is also high
//   headValid out  FIFO not empty
//   headData  out  entry at the read pointer
//   count     out  occupancy 0..DEPTH
module key_fifo #(
  parameter int DEPTH = 8,
  parameter int KEY_W = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             clear,
  input  logic             push,
  input  logic [KEY_W-1:0] pushData,
  input  logic             popReady,
  output logic             headValid,
  output logic [KEY_W-1:0] headData,
  output logic [CNT_W-1:0] count
);

  logic [KEY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] countR;
  logic [CNT_W-1:0] countNxt;
  logic             validR;
  logic             pop;

  // validR always mirrors (countR != 0), so it gates pops directly
  assign pop       = validR & popReady;
  assign headValid = validR;
  assign headData  = mem[rdPtr];
  assign count     = countR;

  // Next occupancy: flush wins, a simultaneous push and pop cancel out
  always_comb begin
    countNxt = countR;
    if (clear) begin
      countNxt = '0;
    end else if (push && !pop) begin
      countNxt = countR + CNT_W'(1);
    end else if (pop && !push) begin
      countNxt = countR - CNT_W'(1);
    end else begin
      countNxt = countR;
    end
  end

  // Pointers, occupancy and the registered non-empty flag
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countR <= '0;
      validR <= 1'b0;
    end else begin
      if (clear) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + PTR_W'(1);
        if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      end
      countR <= countNxt;
      validR <= (countNxt != '0);
    end
  end

  // Storage array; reset to zero so the head reads a known value when empty
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !clear) begin
      mem[wrPtr] <= pushData;
    end
  end

endmodule

// File: rtl/key_entry_reader.sv
// key_entry_reader
// Consumer side of the keypad interpreter KeyReady/KeyRead handshake. A
// pending key is captured into a FIFO and acknowledged by holding KeyRead
// until KeyReady falls, with a timeout bounding the ack length. A full FIFO
// withholds the ack so the scanner stalls instead of losing keys.
// Ports:
//   Clock       in   system clock, rising edge
//   ResetButton in   asynchronous active-low reset
//   KeyReady    in   key pending from the interpreter
//   KeyData     in   key value, stable while KeyReady=1
//   KeyRead     out  registered acknowledge to the interpreter
//   Clear       in   synchronous FIFO flush
//   OutValid    out  FIFO head valid
//   OutData     out  FIFO head value
//   OutReady    in   downstream pop request
//   Count       out  FIFO occupancy 0..DEPTH
//   AckTimeout  out  sticky: an ack lasted ACK_MAX cycles
module key_entry_reader
  import keypad_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ACK_MAX = 100000,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             Clock,
  input  logic             ResetButton,
  input  logic             KeyReady,
  input  logic [KEY_W-1:0] KeyData,
  output logic             KeyRead,
  input  logic             Clear,
  output logic             OutValid,
  output logic [KEY_W-1:0] OutData,
  input  logic             OutReady,
  output logic [CNT_W-1:0] Count,
  output logic             AckTimeout
);

  localparam int             ACK_W    = $clog2(ACK_MAX);
  // Counter value on the last permitted cycle of KeyRead high
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_MAX - 1);

  reader_state_t     stateR;
  reader_state_t     stateNxt;
  logic [ACK_W-1:0]  ackCntR;
  logic [ACK_W-1:0]  ackCntNxt;
  logic              keyReadR;
  logic              ackTimeoutR;
  logic              pushKey;
  logic              timeoutHit;
  logic              fifoFull;

  assign fifoFull   = (Count == CNT_W'(DEPTH));
  assign KeyRead    = keyReadR;
  assign AckTimeout = ackTimeoutR;

  key_fifo #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W)
  ) uFifo (
    .clk       (Clock),
    .rstN      (ResetButton),
    .clear     (Clear),
    .push      (pushKey),
    .pushData  (KeyData),
    .popReady  (OutReady),
    .headValid (OutValid),
    .headData  (OutData),
    .count     (Count)
  );

  // Handshake next-state, capture strobe and ack-length counter
  always_comb begin
    stateNxt   = stateR;
    ackCntNxt  = ackCntR;
    pushKey    = 1'b0;
    timeoutHit = 1'b0;
    case (stateR)
      IDLE: begin
        // Full FIFO: leave the key pending so the scanner stalls
        if (KeyReady && !fifoFull) begin
          pushKey   = 1'b1;
          ackCntNxt = '0;
          stateNxt  = ACK;
        end else begin
          stateNxt = IDLE;
        end
      end
      ACK: begin
        if (!KeyReady) begin
          stateNxt = IDLE;
        end else if (ackCntR == ACK_LAST) begin
          timeoutHit = 1'b1;
          stateNxt   = RECOVER;
        end else begin
          ackCntNxt = ackCntR + ACK_W'(1);
        end
      end
      RECOVER: begin
        // A still-held KeyReady belongs to the key already captured
        if (!KeyReady) begin
          stateNxt = IDLE;
        end else begin
          stateNxt = RECOVER;
        end
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  // State, counter, registered KeyRead and sticky timeout flag
  always_ff @(posedge Clock or negedge ResetButton) begin
    if (!ResetButton) begin
      stateR      <= IDLE;
      ackCntR     <= '0;
      keyReadR    <= 1'b0;
      ackTimeoutR <= 1'b0;
    end else begin
      stateR      <= stateNxt;
      ackCntR     <= ackCntNxt;
      keyReadR    <= (stateNxt == ACK);
      ackTimeoutR <= ackTimeoutR | timeoutHit;
    end
  end

endmodule

// File: doc/key_entry_reader.md
# key_entry_reader

Consumer end of the keypad interpreter's KeyReady/KeyRead handshake. It detects a pending key and captures the 4-bit key value. It then holds KeyRead high until KeyReady falls, bounded by a timeout that keeps KeyRead inside the scanner's 8 ms limit. Captured keys go into a small FIFO, which downstream logic (display driver, code-entry FSM) drains through a valid/ready port. When the FIFO is full the block withholds acknowledgement, so the scanner stalls and no key is lost.

## Interface
- DEPTH, 8: FIFO entries; must be a power of 2, at least 2.
- ACK_MAX, 100000: maximum cycles KeyRead may stay high, 4 ms at 25 MHz; at least 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy count (derived).

- Clock  in  1  single system clock, rising edge.
- ResetButton  in  1  asynchronous, active-low reset.
- KeyReady  in  1  key-pending flag from the interpreter.
- KeyData  in  4  key value from the interpreter's DataOut; stable while KeyReady=1.
- KeyRead  out  1  acknowledge to the interpreter, registered.
- Clear  in  1  synchronous FIFO flush.
- OutValid  out  1  FIFO head is valid.
- OutData  out  4  FIFO head value.
- OutReady  in  1  downstream pop request.
- Count  out  CNT_W  FIFO occupancy, 0..DEPTH.
- AckTimeout  out  1  sticky error flag: ACK_MAX was reached.

## Operation
- FSM states:
  - IDLE: KeyRead=0.
  - ACK: KeyRead=1.
  - RECOVER: KeyRead=0; no capture.
- IDLE, KeyReady=1 and Count<DEPTH: push KeyData, clear the ack counter, go to ACK.
- IDLE, KeyReady=1 and Count==DEPTH: stay in IDLE with no ack. A pop in the same cycle does not free space until the next cycle.
- ACK, KeyReady=0: go to IDLE.
- ACK, KeyReady=1 and the ack counter reaches ACK_MAX-1: set AckTimeout and go to RECOVER.
- RECOVER, KeyReady=0: go to IDLE. This prevents a held KeyReady from being captured twice.
- FIFO behaviour:
  - OutValid = (Count!=0).
  - OutData = entry at the read pointer.
  - Pop when OutValid and OutReady.
  - Simultaneous push and pop leaves Count unchanged.
  - A push into an empty FIFO is visible on the cycle after the push edge (no fall-through).
- Pointers are log2(DEPTH) bits and wrap naturally. Count saturates logically at DEPTH, which the push guard guarantees.
- Clear empties the FIFO (pointers and Count to 0) and wins over any push or pop in the same cycle. The FSM is unaffected, so a key captured in that cycle is still acknowledged but dropped.
- AckTimeout is cleared only by reset.
- Reset values: state IDLE, KeyRead=0, OutValid=0, Count=0, AckTimeout=0, pointers 0. OutData reads entry 0 and is don't-care while OutValid=0.

## Timing
- KeyReady=1 sampled at edge N (IDLE, space available):
  - push occurs at edge N;
  - KeyRead=1 and Count incremented after edge N;
  - OutValid=1 after edge N if the FIFO was empty.
- KeyReady=0 sampled at edge M in ACK: KeyRead=0 after edge M.
- Key-to-output latency is 1 cycle.
- KeyRead high time in ACK is at most ACK_MAX cycles.
- Back-to-back keys need at least one IDLE cycle between ACK periods.
- Asserting ResetButton forces KeyRead=0 immediately, without a clock edge, including mid-ACK.

## Structure
- keypad_pkg, shared with the rest of the keypad design:
  - KEY_W=4;
  - the reader_state_t enum (IDLE, ACK, RECOVER).
- Sub-module key_fifo: synchronous FIFO parameterized by DEPTH and KEY_W, with push, pop, clear, count, and head output.
- key_entry_reader contains the FSM, the ack counter ($clog2(ACK_MAX) bits), and the AckTimeout flag.

## Test plan
- Reset: hold ResetButton=0 while toggling the other inputs -> KeyRead=0, OutValid=0, Count=0, AckTimeout=0.
- Single key: KeyData=4'h7, KeyReady=1, then drop KeyReady 3 cycles after KeyRead rises:
  - KeyRead is high from the cycle after capture until one cycle after KeyReady falls;
  - Count=1 and OutData=7;
  - an OutReady pulse gives Count=0.
- Full stall: with OutReady=0, push 8 keys 1..8, then hold a 9th key (4'hA) pending:
  - Count=8 and KeyRead stays 0;
  - a one-cycle OutReady pulse pops 1, then 4'hA is captured on the following cycle;
  - draining returns 2..8 then A in order.
- Timeout: ACK_MAX=16, KeyReady held 40 cycles with KeyData=4'h3:
  - KeyRead is high for exactly 16 cycles;
  - AckTimeout=1;
  - Count=1, with no duplicate entry when KeyReady falls.
- Clear collision: Clear asserted in the same cycle as a capture of 4'h5 with Count=2 -> Count=0, OutValid=0, and KeyRead still rises.
- Asynchronous reset mid-ACK: ResetButton falls between edges -> KeyRead=0 and Count=0 before the next edge, and the FSM is in IDLE after release.
